// File: rtl/param_mem_pkg.sv
// Shared types and helpers for the param_mem word memory.
// Parity support elsewhere is enabled by the MEM_PARITY_EN macro.
package param_mem_pkg;

  typedef enum logic {ST_INIT, ST_RUN} mem_state_t;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/param_mem_array.sv
// DEPTH x WIDTH storage with byte-enable synchronous write and combinational read.
// With MEM_PARITY_EN defined, one parity bit per byte lane is stored alongside.
module param_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int BW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [BW-1:0]    be_i,
  input  logic [WIDTH-1:0] wdata_i,
`ifdef MEM_PARITY_EN
  input  logic [BW-1:0]    wpar_i,
  output logic [BW-1:0]    rpar_o,
`endif
  output logic [WIDTH-1:0] rdata_o
);

  // No reset: contents are cleared by the init walk in the top.
  logic [WIDTH-1:0] mem_q [DEPTH];
`ifdef MEM_PARITY_EN
  logic [BW-1:0]    par_q [DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < BW; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
`ifdef MEM_PARITY_EN
          par_q[addr_i][i] <= wpar_i[i];
`endif
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];
`ifdef MEM_PARITY_EN
  assign rpar_o  = par_q[addr_i];
`endif

endmodule

// File: rtl/param_mem.sv
// Parametrised single-port word memory with valid/ready request and response channels,
// a clearing walk after reset and out-of-range detection; MEM_PARITY_EN adds lane parity.
module param_mem
  import param_mem_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [BW-1:0]    req_be,
  input  logic [WIDTH-1:0] req_wdata,
`ifdef MEM_PARITY_EN
  input  logic             tst_flip_par,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             init_done
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // ready never depends on valid, and the response holds stable while valid & !ready.

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  mem_state_t       state_q, state_d;
  logic [AW-1:0]    init_cnt_q, init_cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  logic             accept;
  logic             in_range;
  logic             par_err;
  logic             arr_we;
  logic [AW-1:0]    arr_addr;
  logic [BW-1:0]    arr_be;
  logic [WIDTH-1:0] arr_wdata;
  logic [WIDTH-1:0] arr_rdata;
`ifdef MEM_PARITY_EN
  logic [BW-1:0]    arr_wpar;
  logic [BW-1:0]    arr_rpar;
`endif

  assign req_ready  = (state_q == ST_RUN) && (!resp_valid_q || resp_ready);
  assign accept     = req_valid && req_ready;
  assign in_range   = ({1'b0, req_addr} < DEPTH_W);
  assign init_done  = (state_q == ST_RUN);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // During init the array port is owned by the clearing counter.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = req_addr;
    arr_be    = req_be;
    arr_wdata = req_wdata;
`ifdef MEM_PARITY_EN
    arr_wpar  = '0;
`endif
    if (state_q == ST_INIT) begin
      arr_we    = 1'b1;
      arr_addr  = init_cnt_q;
      arr_be    = '1;
      arr_wdata = '0;
`ifdef MEM_PARITY_EN
      for (int i = 0; i < BW; i++) arr_wpar[i] = byte_parity(8'h00);
`endif
    end else begin
      arr_we = accept && req_we && in_range;
`ifdef MEM_PARITY_EN
      for (int i = 0; i < BW; i++)
        arr_wpar[i] = byte_parity(req_wdata[8*i +: 8]) ^ tst_flip_par;
`endif
    end
  end

  always_comb begin
    par_err = 1'b0;
`ifdef MEM_PARITY_EN
    for (int i = 0; i < BW; i++)
      par_err = par_err | (arr_rpar[i] ^ byte_parity(arr_rdata[8*i +: 8]));
`endif
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
        // A new read overwrites a response being taken this cycle: no bubble.
        if (accept && !req_we) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = in_range ? arr_rdata : '0;
          resp_err_d   = !in_range || par_err;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  param_mem_array #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BW(BW)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .be_i    (arr_be),
    .wdata_i (arr_wdata),
`ifdef MEM_PARITY_EN
    .wpar_i  (arr_wpar),
    .rpar_o  (arr_rpar),
`endif
    .rdata_o (arr_rdata)
  );

endmodule
